mcu_uart_tx_arbiter: RTL and testbench
======================================

Name: mcu_uart_tx_arbiter

Overview:
Shares the single MCU-bound UART transmitter between two byte-stream requesters. Source 0 is J1708 bus receive data forwarded to the MCU; source 1 is the FPGA event/diagnostic stream. Arbitration is message-atomic: once a source is granted, it keeps the transmitter until it flags the last byte or goes idle past a timeout. Grants alternate round-robin. The block sits between the requesters and the UART TX data/write/busy interface of the MCU interface block.

Parameters:
IDLE_TIMEOUT_CLKS, 2400, clocks a locked source may stall mid-message before its lock is revoked (100 us at 24 MHz).
START_GUARD_CLKS, 4, max clocks to wait for uart_tx_busy to rise after a write.
CNT_W, 12, width of the timeout counter; must satisfy 2^CNT_W > IDLE_TIMEOUT_CLKS.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  arbiter enable; low blocks new grants.
src0_data  input  8  source 0 byte.
src0_valid  input  1  source 0 byte available.
src0_last  input  1  source 0 byte is the end of its message; qualified by src0_valid.
src0_ready  output  1  one-cycle pulse; source 0 byte accepted.
src1_data  input  8  source 1 byte.
src1_valid  input  1  source 1 byte available.
src1_last  input  1  source 1 byte is the end of its message.
src1_ready  output  1  one-cycle pulse; source 1 byte accepted.
uart_tx_data_in  output  8  byte to transmit.
uart_tx_data_wr  output  1  one-cycle write strobe to the UART TX.
uart_tx_busy  input  1  UART TX busy.
grant  output  2  one-hot current owner; 00 when unlocked.
timeout_err  output  1  one-cycle pulse when a lock is revoked by timeout.

Behaviour:
- Reset values: grant=00, src*_ready=0, uart_tx_data_wr=0, uart_tx_data_in=8'h00, timeout_err=0, state=IDLE, rr_last=1 (source 0 wins the first tie), timeout counter=0.
- FSM states:
  - IDLE:
    - Unlocked, enable=1, and any valid: pick a source. If only one is valid, grant it. If both are valid, grant the one not equal to rr_last. Set grant and go to ISSUE.
    - Locked and the owner's valid=1: go to ISSUE.
    - Locked and the owner's valid=0: increment the timeout counter. When it reaches IDLE_TIMEOUT_CLKS, clear grant, pulse timeout_err, set rr_last=owner, and stay in IDLE.
  - ISSUE (1 cycle):
    - Pulse the owner's ready and pulse uart_tx_data_wr.
    - Register uart_tx_data_in from the owner's data and latch the owner's last.
    - Clear the timeout counter and go to WAIT_START.
  - WAIT_START: wait for uart_tx_busy=1, then go to WAIT_DONE. If busy has not risen within START_GUARD_CLKS cycles, go to WAIT_DONE anyway (covers a UART with zero-cycle busy).
  - WAIT_DONE: wait for uart_tx_busy=0, then:
    - If the latched last=1 or enable=0: clear grant, set rr_last=owner.
    - Either way, go to IDLE.
- A ready pulse means the byte is consumed. The source must present its next byte or drop valid on the following cycle. ready never asserts while uart_tx_busy=1.
- Latency: from a valid grant in IDLE to uart_tx_data_wr is 2 cycles (IDLE→ISSUE; the strobe is registered out of ISSUE). Back-to-back bytes of one message are spaced by UART frame time plus 3 clocks.
- Simultaneous events:
  - The non-owner's valid is ignored while a lock is held.
  - last with timeout is impossible: the counter is cleared on every accepted byte.
  - src valid rising on the exact cycle the timeout fires: the timeout wins, and the source re-arbitrates next cycle.
- enable=0 mid-message: the byte in flight completes, the lock is dropped at WAIT_DONE, and no new grant is made until enable=1. If enable=0 in IDLE while locked, the lock is dropped immediately with no timeout_err.
- rst mid-operation: immediate return to reset values next cycle. An in-flight UART frame is not aborted by this block.
- The timeout counter saturates at IDLE_TIMEOUT_CLKS and never wraps.

Test Plan:
- Single source: src0 sends 3 bytes 0x11, 0x22, 0x33(last) with busy modeled as 10 cycles → three wr strobes with data in order, grant=01 throughout, then 00 after the last byte's busy falls.
- Contention: both valid in the same cycle after reset → src0 is granted first; after its 2-byte message ends, src1 is granted; repeat → src0 next (strict alternation).
- Atomicity: src1 asserts valid while src0 holds the lock on a 4-byte message → no src1_ready until src0's last byte completes.
- Timeout: src0 sends 1 non-last byte, then drops valid for 2400 cycles → timeout_err pulses exactly once, grant=00, and a pending src1 is granted next.
- Enable drop: deassert enable during src0's second byte → that byte completes, grant=00, and no further strobes until enable=1.
- Reset mid-frame: assert rst during WAIT_DONE → next cycle grant=00, wr=0, state IDLE; a subsequent message from src1 proceeds normally.

Source files
------------

// File: rtl/mcu_uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART transmitter between two byte streams.
// A granted source keeps the transmitter until it flags its last byte or stalls past a timeout.
module mcu_uart_tx_arbiter #(
  parameter int unsigned IDLE_TIMEOUT_CLKS = 2400,
  parameter int unsigned START_GUARD_CLKS  = 4,
  parameter int unsigned CNT_W             = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] src0_data,
  input  logic       src0_valid,
  input  logic       src0_last,
  output logic       src0_ready,
  input  logic [7:0] src1_data,
  input  logic       src1_valid,
  input  logic       src1_last,
  output logic       src1_ready,
  output logic [7:0] uart_tx_data_in,
  output logic       uart_tx_data_wr,
  input  logic       uart_tx_busy,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StIssue     = 2'd1;
  localparam logic [1:0] StWaitStart = 2'd2;
  localparam logic [1:0] StWaitDone  = 2'd3;

  localparam int unsigned GuardW = $clog2(START_GUARD_CLKS + 1);
  localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(IDLE_TIMEOUT_CLKS);
  localparam logic [GuardW-1:0] GuardLast  = GuardW'(START_GUARD_CLKS - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              last_q, last_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic              rdy0_q, rdy0_d;
  logic              rdy1_q, rdy1_d;
  logic              to_err_q, to_err_d;

  logic owner;
  logic owner_valid;
  logic pick;

  assign owner       = grant_q[1];
  assign owner_valid = owner ? src1_valid : src0_valid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    guard_d   = guard_q;
    last_d    = last_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    rdy0_d    = 1'b0;
    rdy1_d    = 1'b0;
    to_err_d  = 1'b0;
    // On a tie the source that did not own the transmitter last time wins
    pick      = (src0_valid && src1_valid) ? ~rr_last_q : src1_valid;

    case (state_q)
      StIdle: begin
        if (grant_q == 2'b00) begin
          if (enable && (src0_valid || src1_valid)) begin
            grant_d = pick ? 2'b10 : 2'b01;
            cnt_d   = '0;
            state_d = StIssue;
          end
        end else if (!enable) begin
          grant_d   = 2'b00;
          rr_last_d = owner;
          cnt_d     = '0;
        end else if (cnt_q == TimeoutVal) begin
          // Checked before owner_valid so a late byte loses to the revocation
          grant_d   = 2'b00;
          to_err_d  = 1'b1;
          rr_last_d = owner;
        end else if (owner_valid) begin
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIssue: begin
        rdy0_d  = ~owner;
        rdy1_d  = owner;
        wr_d    = 1'b1;
        data_d  = owner ? src1_data : src0_data;
        last_d  = owner ? src1_last : src0_last;
        cnt_d   = '0;
        guard_d = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (uart_tx_busy || guard_q == GuardLast) begin
          state_d = StWaitDone;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          if (last_q || !enable) begin
            grant_d   = 2'b00;
            rr_last_d = owner;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      guard_q   <= '0;
      last_q    <= 1'b0;
      data_q    <= 8'h00;
      wr_q      <= 1'b0;
      rdy0_q    <= 1'b0;
      rdy1_q    <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      guard_q   <= guard_d;
      last_q    <= last_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      rdy0_q    <= rdy0_d;
      rdy1_q    <= rdy1_d;
      to_err_q  <= to_err_d;
    end
  end

  assign src0_ready      = rdy0_q;
  assign src1_ready      = rdy1_q;
  assign uart_tx_data_in = data_q;
  assign uart_tx_data_wr = wr_q;
  assign grant           = grant_q;
  assign timeout_err     = to_err_q;

endmodule

// File: tb/tb_mcu_uart_tx_arbiter.sv
// Directed scoreboard bench for mcu_uart_tx_arbiter: queued source streams, a simple UART busy
// model, and a monitor that pops the expected {source, byte} on every write strobe.
module tb_mcu_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] src0_data, src1_data;
  logic       src0_valid, src1_valid;
  logic       src0_last, src1_last;
  logic       src0_ready, src1_ready;
  logic [7:0] uart_tx_data_in;
  logic       uart_tx_data_wr;
  logic       uart_tx_busy;
  logic [1:0] grant;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int to_cnt   = 0;
  int busy_len = 10;
  int busy_cnt = 0;

  logic [8:0] q0[$];     // {last, data} presented by source 0
  logic [8:0] q1[$];
  logic [8:0] exp_q[$];  // {source, data} expected on the UART

  always #5 clk = ~clk;

  mcu_uart_tx_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .src0_data       (src0_data),
    .src0_valid      (src0_valid),
    .src0_last       (src0_last),
    .src0_ready      (src0_ready),
    .src1_data       (src1_data),
    .src1_valid      (src1_valid),
    .src1_last       (src1_last),
    .src1_ready      (src1_ready),
    .uart_tx_data_in (uart_tx_data_in),
    .uart_tx_data_wr (uart_tx_data_wr),
    .uart_tx_busy    (uart_tx_busy),
    .grant           (grant),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Source drivers: hold the queue head until a ready pulse consumes it
  initial begin
    src0_valid = 1'b0; src0_data = 8'h00; src0_last = 1'b0;
    forever begin
      @(negedge clk);
      if (src0_ready && q0.size() > 0) void'(q0.pop_front());
      src0_valid = (q0.size() > 0);
      src0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      src0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    end
  end

  initial begin
    src1_valid = 1'b0; src1_data = 8'h00; src1_last = 1'b0;
    forever begin
      @(negedge clk);
      if (src1_ready && q1.size() > 0) void'(q1.pop_front());
      src1_valid = (q1.size() > 0);
      src1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      src1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  // UART model: busy for busy_len cycles after each strobe (busy_len=0 never raises busy)
  initial begin
    uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) busy_cnt--;
      if (uart_tx_data_wr) busy_cnt = busy_len;
      uart_tx_busy = (busy_cnt > 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (uart_tx_data_wr) begin
          wr_cnt++;
          chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_data", {24'd0, uart_tx_data_in}, {24'd0, e[7:0]});
            chk("wr_grant", {30'd0, grant}, e[8] ? 32'd2 : 32'd1);
          end
        end
        if (timeout_err) begin
          to_cnt++;
          chk("timeout_grant", {30'd0, grant}, 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || grant != 2'b00 || uart_tx_busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, n < maxc}, 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int r1;
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_wr", {31'd0, uart_tx_data_wr}, 32'd0);
    chk("rst_data", {24'd0, uart_tx_data_in}, 32'd0);
    chk("rst_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single source, three-byte message
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b0, 8'h33});
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    wait_done("single_done", 200);
    chk("single_wr_cnt", wr_cnt, 32'd3);

    // Contention after reset: src0, src1, src0, src1
    do_reset();
    exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b1, 8'hB1}); exp_q.push_back({1'b1, 8'hB2});
    exp_q.push_back({1'b0, 8'hA3}); exp_q.push_back({1'b0, 8'hA4});
    exp_q.push_back({1'b1, 8'hB3}); exp_q.push_back({1'b1, 8'hB4});
    q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b1, 8'hA2});
    q0.push_back({1'b0, 8'hA3}); q0.push_back({1'b1, 8'hA4});
    q1.push_back({1'b0, 8'hB1}); q1.push_back({1'b1, 8'hB2});
    q1.push_back({1'b0, 8'hB3}); q1.push_back({1'b1, 8'hB4});
    wait_done("rr_done", 600);
    chk("rr_wr_cnt", wr_cnt, 32'd11);

    // Atomicity with zero-cycle busy: src1 must wait for src0's last byte
    busy_len = 0;
    exp_q.push_back({1'b0, 8'hC1}); exp_q.push_back({1'b0, 8'hC2});
    exp_q.push_back({1'b0, 8'hC3}); exp_q.push_back({1'b0, 8'hC4});
    exp_q.push_back({1'b1, 8'hD1}); exp_q.push_back({1'b1, 8'hD2});
    q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b0, 8'hC2});
    q0.push_back({1'b0, 8'hC3}); q0.push_back({1'b1, 8'hC4});
    repeat (3) @(negedge clk);
    q1.push_back({1'b0, 8'hD1}); q1.push_back({1'b1, 8'hD2});
    r1 = 0;
    n  = 0;
    while (exp_q.size() > 2 && n < 300) begin
      @(negedge clk);
      if (src1_ready) r1++;
      n++;
    end
    chk("atomic_no_src1_ready", r1, 32'd0);
    wait_done("atomic_done", 300);
    chk("atomic_wr_cnt", wr_cnt, 32'd17);
    busy_len = 10;

    // Timeout: src0 stalls after a non-last byte, src1 waits then wins
    exp_q.push_back({1'b0, 8'h5A}); exp_q.push_back({1'b1, 8'h6B});
    q0.push_back({1'b0, 8'h5A});
    q1.push_back({1'b1, 8'h6B});
    wait_done("timeout_done", 4000);
    chk("timeout_pulses", to_cnt, 32'd1);
    chk("timeout_wr_cnt", wr_cnt, 32'd19);

    // Enable drop during the second byte
    exp_q.push_back({1'b0, 8'h71}); exp_q.push_back({1'b0, 8'h72});
    q0.push_back({1'b0, 8'h71}); q0.push_back({1'b0, 8'h72}); q0.push_back({1'b1, 8'h73});
    base = wr_cnt;
    n = 0;
    while (wr_cnt < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    chk("en_second_byte_seen", {31'd0, n < 200}, 32'd1);
    wait_done("en_drop_done", 200);
    repeat (30) @(negedge clk);
    chk("en_no_more_wr", wr_cnt, base + 2);
    chk("en_grant_clear", {30'd0, grant}, 32'd0);
    exp_q.push_back({1'b0, 8'h73});
    enable = 1'b1;
    wait_done("en_resume_done", 200);

    // Reset while waiting for the frame to finish
    exp_q.push_back({1'b0, 8'h81});
    q0.push_back({1'b0, 8'h81}); q0.push_back({1'b1, 8'h82});
    base = wr_cnt;
    n = 0;
    while (wr_cnt == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q0.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_grant", {30'd0, grant}, 32'd0);
    chk("rst_mid_wr", {31'd0, uart_tx_data_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({1'b1, 8'h91}); exp_q.push_back({1'b1, 8'h92});
    q1.push_back({1'b0, 8'h91}); q1.push_back({1'b1, 8'h92});
    wait_done("post_rst_done", 300);

    chk("total_wr_cnt", wr_cnt, 32'd25);
    chk("total_timeouts", to_cnt, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
